// File: rtl/activation_lut_stream.sv
// Streaming multi-lane activation lookup table with a runtime-loadable table.
// All lanes share one register-array table; lookups use a 2-stage stallable pipeline.
module activation_lut_stream #(
  parameter int unsigned DATA_IN_0_PRECISION_0       = 7,
  parameter int unsigned DATA_OUT_0_PRECISION_0      = 7,
  parameter int unsigned DATA_IN_0_PARALLELISM_DIM_0 = 4
) (
  input  logic                                                          clk,
  input  logic                                                          rst,
  input  logic [DATA_IN_0_PARALLELISM_DIM_0*DATA_IN_0_PRECISION_0-1:0]  data_in_0,
  input  logic                                                          data_in_0_valid,
  output logic                                                          data_in_0_ready,
  output logic [DATA_IN_0_PARALLELISM_DIM_0*DATA_OUT_0_PRECISION_0-1:0] data_out_0,
  output logic                                                          data_out_0_valid,
  input  logic                                                          data_out_0_ready,
  input  logic                                                          lut_load_start,
  input  logic [DATA_OUT_0_PRECISION_0-1:0]                             lut_wr_data,
  input  logic                                                          lut_wr_valid,
  output logic                                                          lut_wr_ready,
  output logic                                                          lut_ready
);

  localparam int unsigned IN_W  = DATA_IN_0_PRECISION_0;
  localparam int unsigned OUT_W = DATA_OUT_0_PRECISION_0;
  localparam int unsigned PAR   = DATA_IN_0_PARALLELISM_DIM_0;
  localparam int unsigned DEPTH = 1 << IN_W;

  typedef enum logic [1:0] {
    S_EMPTY,
    S_LOAD,
    S_RUN,
    S_DRAIN
  } state_t;

  state_t                 r_state;
  state_t                 w_state_nxt;
  logic [IN_W-1:0]        r_wr_addr;
  logic [OUT_W-1:0]       r_table [DEPTH];

  logic [PAR*IN_W-1:0]    r_s1_data;
  logic                   r_s1_valid;
  logic [PAR*OUT_W-1:0]   r_s2_data;
  logic                   r_s2_valid;

  logic                   w_stall;
  logic                   w_accept;
  logic                   w_wr_en;
  logic                   w_wr_last;
  logic [PAR*OUT_W-1:0]   w_lut_rd;

  assign w_stall   = r_s2_valid & ~data_out_0_ready;
  assign w_accept  = data_in_0_valid & data_in_0_ready;
  // A load-start pulse in LOAD restarts the pass and suppresses any write in that cycle.
  assign w_wr_en   = (r_state == S_LOAD) & lut_wr_valid & ~lut_load_start & ~rst;
  assign w_wr_last = &r_wr_addr;

  assign data_in_0_ready  = (r_state == S_RUN) & ~w_stall;
  assign data_out_0       = r_s2_data;
  assign data_out_0_valid = r_s2_valid;
  assign lut_wr_ready     = (r_state == S_LOAD);
  assign lut_ready        = (r_state == S_RUN);

  always_ff @(posedge clk) begin
    if (rst) r_state <= S_EMPTY;
    else     r_state <= w_state_nxt;
  end

  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      S_EMPTY: if (lut_load_start) w_state_nxt = S_LOAD;
      S_LOAD:  if (w_wr_en && w_wr_last) w_state_nxt = S_RUN;
      S_RUN:   if (lut_load_start) w_state_nxt = S_DRAIN;
      S_DRAIN: if (!r_s1_valid && !r_s2_valid) w_state_nxt = S_LOAD;
      default: w_state_nxt = S_EMPTY;
    endcase
  end

  // Held at zero outside LOAD so every entry into LOAD starts at address 0.
  always_ff @(posedge clk) begin
    if (rst)                      r_wr_addr <= '0;
    else if (r_state != S_LOAD)   r_wr_addr <= '0;
    else if (lut_load_start)      r_wr_addr <= '0;
    else if (lut_wr_valid)        r_wr_addr <= r_wr_addr + 1'b1;
  end

  always_ff @(posedge clk) begin
    if (w_wr_en) r_table[r_wr_addr] <= lut_wr_data;
  end

  always_comb begin
    w_lut_rd = '0;
    for (int unsigned i = 0; i < PAR; i++) begin
      w_lut_rd[i*OUT_W +: OUT_W] = r_table[r_s1_data[i*IN_W +: IN_W]];
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_s1_valid <= 1'b0;
      r_s1_data  <= '0;
      r_s2_valid <= 1'b0;
      r_s2_data  <= '0;
    end else if (!w_stall) begin
      r_s1_valid <= w_accept;
      if (w_accept)   r_s1_data <= data_in_0;
      r_s2_valid <= r_s1_valid;
      if (r_s1_valid) r_s2_data <= w_lut_rd;
    end
  end

endmodule

// File: tb/tb_activation_lut_stream.sv
// Directed self-checking bench for activation_lut_stream: load, lookup, stall,
// reload with drain, load restart and reset-in-flight scenarios.
module tb_activation_lut_stream;

  localparam int IN_W  = 7;
  localparam int OUT_W = 7;
  localparam int PAR   = 4;

  logic                  clk = 1'b0;
  logic                  rst;
  logic [PAR*IN_W-1:0]   data_in_0;
  logic                  data_in_0_valid;
  logic                  data_in_0_ready;
  logic [PAR*OUT_W-1:0]  data_out_0;
  logic                  data_out_0_valid;
  logic                  data_out_0_ready;
  logic                  lut_load_start;
  logic [OUT_W-1:0]      lut_wr_data;
  logic                  lut_wr_valid;
  logic                  lut_wr_ready;
  logic                  lut_ready;

  int n_tests = 0;
  int n_fail  = 0;

  activation_lut_stream #(
    .DATA_IN_0_PRECISION_0      (IN_W),
    .DATA_OUT_0_PRECISION_0     (OUT_W),
    .DATA_IN_0_PARALLELISM_DIM_0(PAR)
  ) dut (
    .clk             (clk),
    .rst             (rst),
    .data_in_0       (data_in_0),
    .data_in_0_valid (data_in_0_valid),
    .data_in_0_ready (data_in_0_ready),
    .data_out_0      (data_out_0),
    .data_out_0_valid(data_out_0_valid),
    .data_out_0_ready(data_out_0_ready),
    .lut_load_start  (lut_load_start),
    .lut_wr_data     (lut_wr_data),
    .lut_wr_valid    (lut_wr_valid),
    .lut_wr_ready    (lut_wr_ready),
    .lut_ready       (lut_ready)
  );

  always #5 clk = ~clk;

  initial begin
    #500000;
    $display("FAIL watchdog: got timeout, expected completion");
    $fatal(1);
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
    end
  endtask

  function automatic logic [PAR*IN_W-1:0] pack4(input int a, input int b, input int c, input int d);
    logic [6:0] la, lb, lc, ld;
    la = 7'(a); lb = 7'(b); lc = 7'(c); ld = 7'(d);
    return {ld, lc, lb, la};
  endfunction

  function automatic logic [OUT_W-1:0] tab_val(input int mode, input int i);
    case (mode)
      0:       return (i < 64) ? 7'(i) : 7'd0;
      1:       return 7'(127 - i);
      2:       return 7'(i * 3);
      default: return 7'h55;
    endcase
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic pulse_start();
    lut_load_start = 1'b1;
    tick();
    lut_load_start = 1'b0;
  endtask

  task automatic wait_wr_ready();
    for (int k = 0; k < 10 && !lut_wr_ready; k++) tick();
    check("wait_wr_ready", lut_wr_ready, 1);
  endtask

  task automatic write_entries(input int mode, input int count);
    for (int i = 0; i < count; i++) begin
      lut_wr_valid = 1'b1;
      lut_wr_data  = tab_val(mode, i);
      if (count == 128 && i == 127) check("lut_ready_before_last", lut_ready, 0);
      tick();
    end
    lut_wr_valid = 1'b0;
    #1;
    if (count == 128) check("lut_ready_after_last", lut_ready, 1);
  endtask

  task automatic send_beat(input string tag, input logic [PAR*IN_W-1:0] d, input logic [PAR*OUT_W-1:0] exp);
    data_in_0        = d;
    data_in_0_valid  = 1'b1;
    data_out_0_ready = 1'b1;
    #1;
    check({tag, "_in_ready"}, data_in_0_ready, 1);
    tick();
    data_in_0_valid = 1'b0;
    #1;
    check({tag, "_lat1_valid"}, data_out_0_valid, 0);
    tick();
    check({tag, "_lat2_valid"}, data_out_0_valid, 1);
    check({tag, "_data"}, data_out_0, exp);
    tick();
  endtask

  initial begin
    int cyc, tx, rx;
    logic prev_stall;
    logic [PAR*OUT_W-1:0] held;

    rst = 1'b1;
    data_in_0 = '0;
    data_in_0_valid = 1'b0;
    data_out_0_ready = 1'b1;
    lut_load_start = 1'b0;
    lut_wr_data = '0;
    lut_wr_valid = 1'b0;
    tick();
    tick();

    // Reset state and no acceptance in EMPTY
    check("rst_in_ready", data_in_0_ready, 0);
    check("rst_lut_ready", lut_ready, 0);
    check("rst_wr_ready", lut_wr_ready, 0);
    check("rst_out_valid", data_out_0_valid, 0);
    check("rst_out_data", data_out_0, 0);
    rst = 1'b0;
    data_in_0 = pack4(1, 2, 3, 4);
    data_in_0_valid = 1'b1;
    for (int k = 0; k < 3; k++) begin
      #1;
      check("empty_in_ready", data_in_0_ready, 0);
      tick();
    end
    data_in_0_valid = 1'b0;
    check("empty_out_valid", data_out_0_valid, 0);

    // SiLU-style table and first lookup
    pulse_start();
    wait_wr_ready();
    write_entries(0, 128);
    check("run_idle_out_valid", data_out_0_valid, 0);
    send_beat("silu", pack4(3, 63, 64, 127), pack4(3, 63, 0, 0));

    // 20-beat stream with a 5-cycle downstream stall
    cyc = 0; tx = 0; rx = 0; prev_stall = 1'b0; held = '0;
    while (rx < 20 && cyc < 200) begin
      data_out_0_ready = !(cyc >= 6 && cyc < 11);
      data_in_0_valid  = (tx < 20);
      data_in_0        = pack4(tx, tx + 1, tx + 2, tx + 3);
      #1;
      if (prev_stall) check("stall_hold", data_out_0, held);
      if (data_out_0_valid && data_out_0_ready) begin
        check("stream_beat", data_out_0, pack4(rx, rx + 1, rx + 2, rx + 3));
        rx++;
      end
      prev_stall = data_out_0_valid & ~data_out_0_ready;
      held = data_out_0;
      if (data_in_0_valid && data_in_0_ready) tx++;
      tick();
      cyc++;
    end
    data_in_0_valid = 1'b0;
    data_out_0_ready = 1'b1;
    check("stream_count", rx, 20);
    tick();

    // Reload with two beats in flight
    data_in_0_valid = 1'b1;
    data_in_0 = pack4(3, 63, 64, 127);
    tick();
    data_in_0 = pack4(10, 20, 30, 100);
    tick();
    data_in_0_valid = 1'b0;
    lut_load_start = 1'b1;
    #1;
    check("inflight_a_valid", data_out_0_valid, 1);
    check("inflight_a_data", data_out_0, pack4(3, 63, 0, 0));
    tick();
    lut_load_start = 1'b0;
    data_in_0_valid = 1'b1;
    data_in_0 = pack4(1, 1, 1, 1);
    #1;
    check("drain_in_ready", data_in_0_ready, 0);
    check("drain_lut_ready", lut_ready, 0);
    check("inflight_b_valid", data_out_0_valid, 1);
    check("inflight_b_data", data_out_0, pack4(10, 20, 30, 0));
    tick();
    check("drain_in_ready2", data_in_0_ready, 0);
    check("drain_out_empty", data_out_0_valid, 0);
    data_in_0_valid = 1'b0;
    wait_wr_ready();
    write_entries(1, 128);
    send_beat("inv", pack4(3, 0, 127, 64), pack4(124, 127, 0, 63));

    // Load restart after 10 writes
    pulse_start();
    wait_wr_ready();
    write_entries(3, 10);
    lut_load_start = 1'b1;
    lut_wr_valid = 1'b1;
    lut_wr_data = 7'h7f;
    tick();
    lut_load_start = 1'b0;
    lut_wr_valid = 1'b0;
    #1;
    check("restart_wr_ready", lut_wr_ready, 1);
    check("restart_lut_ready", lut_ready, 0);
    write_entries(2, 128);
    send_beat("restart", pack4(0, 5, 9, 100), pack4(0, 15, 27, 44));

    // Reset during LOAD at address 50
    pulse_start();
    wait_wr_ready();
    write_entries(0, 50);
    rst = 1'b1;
    tick();
    rst = 1'b0;
    check("rstload_wr_ready", lut_wr_ready, 0);
    check("rstload_lut_ready", lut_ready, 0);
    check("rstload_out_valid", data_out_0_valid, 0);

    // Reset during RUN with a stalled output
    pulse_start();
    wait_wr_ready();
    write_entries(0, 128);
    data_out_0_ready = 1'b0;
    data_in_0 = pack4(3, 3, 3, 3);
    data_in_0_valid = 1'b1;
    tick();
    data_in_0_valid = 1'b0;
    tick();
    check("stalled_valid", data_out_0_valid, 1);
    check("stalled_in_ready", data_in_0_ready, 0);
    check("stalled_data", data_out_0, pack4(3, 3, 3, 3));
    rst = 1'b1;
    tick();
    rst = 1'b0;
    check("rstrun_out_valid", data_out_0_valid, 0);
    check("rstrun_out_data", data_out_0, 0);
    check("rstrun_lut_ready", lut_ready, 0);
    check("rstrun_wr_ready", lut_wr_ready, 0);
    tick();
    check("rstrun_still_empty", lut_ready, 0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
